// File: rtl/ds_intf_bit_if.sv
// Bit-level 1-wire controller interface: request/response handshake plus the
// open-drain bus pins. The master side is the user logic that issues
// requests. It also models the wire, so it supplies dq_in and observes dq_oe.
interface ds_intf_bit_if;
   logic rst_en_bit;
   logic wr_en_bit;
   logic wdata_bit;
   logic rd_en_bit;
   logic rdata_bit;
   logic rdata_vld_bit;
   logic rdy_bit;
   logic pres_vld;
   logic pres_ok;
   logic dq_in;
   logic dq_oe;

   modport master (
      output rst_en_bit, wr_en_bit, wdata_bit, rd_en_bit, dq_in,
      input  rdata_bit, rdata_vld_bit, rdy_bit, pres_vld, pres_ok, dq_oe
   );

   modport slave (
      input  rst_en_bit, wr_en_bit, wdata_bit, rd_en_bit, dq_in,
      output rdata_bit, rdata_vld_bit, rdy_bit, pres_vld, pres_ok, dq_oe
   );
endinterface

// File: rtl/ds_intf_bit.sv
// 1-wire bit engine: reset/presence sequence, write-bit slot and read-bit slot.
// A single cycle counter times every phase and is cleared on each state entry.
// All outputs are registered.
module ds_intf_bit #(
   parameter int T_RST_LOW  = 12000,
   parameter int T_RST_REL  = 12000,
   parameter int T_PRES_SMP = 1750,
   parameter int T_SLOT     = 1750,
   parameter int T_W0_LOW   = 1500,
   parameter int T_W1_LOW   = 50,
   parameter int T_RD_SMP   = 300,
   parameter int T_REC      = 50
) (
   input  logic         clk,
   input  logic         rst,
   ds_intf_bit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_LOW,
      S_RST_REL,
      S_WR_SLOT,
      S_RD_SLOT,
      S_REC
   } state_t;

   // Counter sized to the longest timing parameter so it never wraps in a state.
   localparam int MAX_A = (T_RST_LOW > T_RST_REL) ? T_RST_LOW : T_RST_REL;
   localparam int MAX_B = (T_SLOT > T_REC) ? T_SLOT : T_REC;
   localparam int MAX_C = (T_PRES_SMP > T_RD_SMP) ? T_PRES_SMP : T_RD_SMP;
   localparam int MAX_D = (T_W0_LOW > T_W1_LOW) ? T_W0_LOW : T_W1_LOW;
   localparam int MAX_E = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_F = (MAX_C > MAX_D) ? MAX_C : MAX_D;
   localparam int MAX_T = (MAX_E > MAX_F) ? MAX_E : MAX_F;
   localparam int CW    = $clog2(MAX_T + 1);

   localparam logic [CW-1:0] C_RST_LOW_END = CW'(T_RST_LOW - 1);
   localparam logic [CW-1:0] C_RST_REL_END = CW'(T_RST_REL - 1);
   localparam logic [CW-1:0] C_PRES_SMP    = CW'(T_PRES_SMP - 1);
   localparam logic [CW-1:0] C_SLOT_END    = CW'(T_SLOT - 1);
   localparam logic [CW-1:0] C_W0_LOW      = CW'(T_W0_LOW);
   localparam logic [CW-1:0] C_W1_LOW      = CW'(T_W1_LOW);
   localparam logic [CW-1:0] C_RD_SMP      = CW'(T_RD_SMP - 1);
   localparam logic [CW-1:0] C_REC_END     = CW'(T_REC - 1);
   // rdata_vld_bit is registered, so it is armed one count before the last REC cycle.
   localparam logic [CW-1:0] C_REC_VLD     = CW'((T_REC >= 2) ? T_REC - 2 : 0);
   localparam bit            REC_ONE       = (T_REC == 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_wdata;
   logic          r_is_rd;
   logic          r_dq_oe;
   logic          r_rdy;
   logic          r_rdata;
   logic          r_rdata_vld;
   logic          r_pres_vld;
   logic          r_pres_ok;

   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_low_len;

   assign w_cnt_nxt = r_cnt + CW'(1);
   // A read slot is initiated with the short (write-1) low pulse.
   assign w_low_len = (r_state == S_WR_SLOT && !r_wdata) ? C_W0_LOW : C_W1_LOW;

   assign bus.dq_oe         = r_dq_oe;
   assign bus.rdy_bit       = r_rdy;
   assign bus.rdata_bit     = r_rdata;
   assign bus.rdata_vld_bit = r_rdata_vld;
   assign bus.pres_vld      = r_pres_vld;
   assign bus.pres_ok       = r_pres_ok;

   // Bus synchroniser plus the sequencing FSM, with every output registered.
   // NOTE: rst is asynchronous so dq_oe drops the instant rst rises, even mid-slot;
   // all state here uses non-blocking assignments so every register updates from
   // pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_wdata     <= 1'b0;
         r_is_rd     <= 1'b0;
         r_dq_oe     <= 1'b0;
         r_rdy       <= 1'b0;
         r_rdata     <= 1'b0;
         r_rdata_vld <= 1'b0;
         r_pres_vld  <= 1'b0;
         r_pres_ok   <= 1'b0;
      end else begin
         r_sync1     <= bus.dq_in;
         r_sync2     <= r_sync1;
         r_rdata_vld <= 1'b0;
         r_pres_vld  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (r_rdy && bus.rst_en_bit) begin
                  r_state <= S_RST_LOW;
                  r_dq_oe <= 1'b1;
                  r_rdy   <= 1'b0;
               end else if (r_rdy && bus.wr_en_bit) begin
                  r_state <= S_WR_SLOT;
                  r_wdata <= bus.wdata_bit;
                  r_is_rd <= 1'b0;
                  r_dq_oe <= 1'b1;
                  r_rdy   <= 1'b0;
               end else if (r_rdy && bus.rd_en_bit) begin
                  r_state <= S_RD_SLOT;
                  r_is_rd <= 1'b1;
                  r_dq_oe <= 1'b1;
                  r_rdy   <= 1'b0;
               end else begin
                  r_rdy <= 1'b1;
               end
            end

            S_RST_LOW: begin
               if (r_cnt == C_RST_LOW_END) begin
                  r_state <= S_RST_REL;
                  r_cnt   <= '0;
                  r_dq_oe <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end

            S_RST_REL: begin
               if (r_cnt == C_PRES_SMP) begin
                  r_pres_ok <= ~r_sync2;
               end
               if (r_cnt == C_RST_REL_END) begin
                  r_state    <= S_IDLE;
                  r_cnt      <= '0;
                  r_pres_vld <= 1'b1;
                  r_rdy      <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end

            S_WR_SLOT, S_RD_SLOT: begin
               if (r_state == S_RD_SLOT && r_cnt == C_RD_SMP) begin
                  r_rdata <= r_sync2;
               end
               if (r_cnt == C_SLOT_END) begin
                  r_state     <= S_REC;
                  r_cnt       <= '0;
                  r_dq_oe     <= 1'b0;
                  r_rdata_vld <= r_is_rd && REC_ONE;
               end else begin
                  r_cnt   <= w_cnt_nxt;
                  r_dq_oe <= (w_cnt_nxt < w_low_len);
               end
            end

            S_REC: begin
               if (r_cnt == C_REC_END) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_rdy   <= 1'b1;
               end else begin
                  r_cnt       <= w_cnt_nxt;
                  r_rdata_vld <= r_is_rd && !REC_ONE && (r_cnt == C_REC_VLD);
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_dq_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ds_intf_bit.sv
// Bench for ds_intf_bit with timings scaled down by ten. Stimulus pushes the
// expected strobes, rdy_bit returns and dq_oe pulse widths into queues. A
// monitor pops and compares them whenever the DUT presents one. A small
// 1-wire slave model drives the line.
module tb_ds_intf_bit;

   localparam int T_RST_LOW  = 1200;
   localparam int T_RST_REL  = 1200;
   localparam int T_PRES_SMP = 175;
   localparam int T_SLOT     = 175;
   localparam int T_W0_LOW   = 150;
   localparam int T_W1_LOW   = 5;
   localparam int T_RD_SMP   = 30;
   localparam int T_REC      = 5;
   localparam int BUSY_MAX   = T_RST_LOW + T_RST_REL + 20;

   typedef enum int {EV_PRES, EV_RD, EV_RDY} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      bit          value;
      int unsigned at;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   always #20 clk = ~clk;

   ds_intf_bit_if bus ();

   ds_intf_bit #(
      .T_RST_LOW (T_RST_LOW),
      .T_RST_REL (T_RST_REL),
      .T_PRES_SMP(T_PRES_SMP),
      .T_SLOT    (T_SLOT),
      .T_W0_LOW  (T_W0_LOW),
      .T_W1_LOW  (T_W1_LOW),
      .T_RD_SMP  (T_RD_SMP),
      .T_REC     (T_REC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   ev_t         ev_q[$];
   int unsigned pulse_q[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   // ---------------- 1-wire line and slave device model ----------------
   logic        dev_low = 1'b0;
   bit          dev_present = 1'b0;
   bit          dev_rd_bit = 1'b1;
   int unsigned rd_req_seq = 0;
   int unsigned rd_srv_seq = 0;
   int unsigned hi_start = 0;
   int unsigned win_from = 0;
   int unsigned win_until = 0;
   bit          dev_prev_oe = 1'b0;

   // Wired-AND line: low when the master or the device pulls it.
   assign bus.dq_in = !((bus.dq_oe === 1'b1) || dev_low);

   // Device reacts to line activity: a presence pulse after a long reset
   // pulse, and a held-low window at the start of a read-0 slot.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         win_from    = 0;
         win_until   = 0;
         dev_prev_oe = 1'b0;
      end else begin
         if (bus.dq_oe === 1'b1 && !dev_prev_oe) begin
            hi_start = cyc;
            if (rd_srv_seq != rd_req_seq) begin
               rd_srv_seq = rd_req_seq;
               if (!dev_rd_bit) begin
                  win_from  = cyc;
                  win_until = cyc + $urandom_range(40, 50);
               end
            end
         end
         if (bus.dq_oe !== 1'b1 && dev_prev_oe && (cyc - hi_start) >= T_RST_LOW && dev_present) begin
            win_from  = cyc + $urandom_range(37, 150);
            win_until = win_from + $urandom_range(150, 600);
         end
         dev_prev_oe = (bus.dq_oe === 1'b1);
      end
      dev_low = (cyc >= win_from) && (cyc < win_until);
   end

   // ---------------- monitor / scoreboard ----------------
   int unsigned mon_run = 0;
   bit          mon_prev_rdy = 1'b0;

   always @(negedge clk) begin
      ev_t e;
      if (rst === 1'b1) begin
         mon_run = 0;
      end else if (bus.dq_oe === 1'b1) begin
         mon_run++;
      end else if (mon_run > 0) begin
         if (pulse_q.size() == 0) check("unexpected_dq_oe_pulse", mon_run, 0);
         else check("dq_oe_low_time", mon_run, pulse_q.pop_front());
         mon_run = 0;
      end

      if (bus.pres_vld === 1'b1 && bus.rdata_vld_bit === 1'b1)
         check("strobe_overlap", {31'd0, bus.rdata_vld_bit}, 0);

      if (bus.pres_vld === 1'b1 || bus.rdata_vld_bit === 1'b1) begin
         if (ev_q.size() == 0) begin
            check("unexpected_strobe", {31'd0, bus.pres_vld | bus.rdata_vld_bit}, 0);
         end else begin
            e = ev_q.pop_front();
            check("strobe_kind", (bus.pres_vld === 1'b1) ? EV_PRES : EV_RD, e.kind);
            check("strobe_value", {31'd0, (bus.pres_vld === 1'b1) ? bus.pres_ok : bus.rdata_bit},
                  {31'd0, e.value});
            check("strobe_cycle", cyc, e.at);
         end
      end

      if (bus.rdy_bit === 1'b1 && !mon_prev_rdy) begin
         if (ev_q.size() == 0) begin
            check("unexpected_rdy_rise", {31'd0, bus.rdy_bit}, 0);
         end else begin
            e = ev_q.pop_front();
            check("rdy_kind", EV_RDY, e.kind);
            check("rdy_cycle", cyc, e.at);
         end
      end
      mon_prev_rdy = (bus.rdy_bit === 1'b1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rdy(input int budget);
      int k = 0;
      while (bus.rdy_bit !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (bus.rdy_bit !== 1'b1) check("rdy_timeout", {31'd0, bus.rdy_bit}, 1);
   endtask

   function automatic ev_t mk_ev(input ev_kind_t k, input bit v, input int unsigned at);
      ev_t e;
      e.kind  = k;
      e.value = v;
      e.at    = at;
      return e;
   endfunction

   // Reference model: what each operation should produce, from the bus timing rules.
   task automatic expect_op(input int op, input bit val, input int unsigned a);
      case (op)
         0: begin
            pulse_q.push_back(T_RST_LOW);
            ev_q.push_back(mk_ev(EV_PRES, val, a + T_RST_LOW + T_RST_REL));
            ev_q.push_back(mk_ev(EV_RDY, 1'b0, a + T_RST_LOW + T_RST_REL));
         end
         1: begin
            pulse_q.push_back(val ? T_W1_LOW : T_W0_LOW);
            ev_q.push_back(mk_ev(EV_RDY, 1'b0, a + T_SLOT + T_REC));
         end
         default: begin
            pulse_q.push_back(T_W1_LOW);
            ev_q.push_back(mk_ev(EV_RD, val, a + T_SLOT + T_REC - 1));
            ev_q.push_back(mk_ev(EV_RDY, 1'b0, a + T_SLOT + T_REC));
         end
      endcase
   endtask

   // Issue one op (0 reset, 1 write, 2 read) from a negedge with rdy_bit high,
   // disturb wdata afterwards, fire one request while busy, then wait for idle.
   task automatic issue(input int op, input bit val);
      int busy_req;
      expect_op(op, val, cyc + 1);
      case (op)
         0: begin
            dev_present    = val;
            bus.rst_en_bit = 1'b1;
         end
         1: begin
            bus.wr_en_bit = 1'b1;
            bus.wdata_bit = val;
         end
         default: begin
            dev_rd_bit = val;
            rd_req_seq++;
            bus.rd_en_bit = 1'b1;
         end
      endcase
      @(negedge clk);
      bus.rst_en_bit = 1'b0;
      bus.wr_en_bit  = 1'b0;
      bus.rd_en_bit  = 1'b0;
      bus.wdata_bit  = ~val;
      wait_cycles($urandom_range(1, 40));
      busy_req = $urandom_range(0, 2);
      bus.rst_en_bit = (busy_req == 0);
      bus.wr_en_bit  = (busy_req == 1);
      bus.rd_en_bit  = (busy_req == 2);
      @(negedge clk);
      bus.rst_en_bit = 1'b0;
      bus.wr_en_bit  = 1'b0;
      bus.rd_en_bit  = 1'b0;
      wait_rdy(BUSY_MAX);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int op;
      int n_rst;
      bit val;
      rst            = 1'b0;
      bus.rst_en_bit = 1'b0;
      bus.wr_en_bit  = 1'b0;
      bus.wdata_bit  = 1'b0;
      bus.rd_en_bit  = 1'b0;
      #5 rst = 1'b1;

      // Reset state.
      wait_cycles(3);
      check("rst_dq_oe", {31'd0, bus.dq_oe}, 0);
      check("rst_rdy", {31'd0, bus.rdy_bit}, 0);
      check("rst_rdata", {31'd0, bus.rdata_bit}, 0);
      check("rst_rdata_vld", {31'd0, bus.rdata_vld_bit}, 0);
      check("rst_pres_vld", {31'd0, bus.pres_vld}, 0);
      check("rst_pres_ok", {31'd0, bus.pres_ok}, 0);
      rst = 1'b0;
      ev_q.push_back(mk_ev(EV_RDY, 1'b0, cyc + 1));
      wait_rdy(10);

      // Directed: reset with and without presence, write 0/1, read 0/1.
      issue(0, 1'b1);
      issue(0, 1'b0);
      issue(1, 1'b0);
      issue(1, 1'b1);
      issue(2, 1'b0);
      issue(2, 1'b1);

      // All three requests together: only the reset runs; a busy write is dropped.
      dev_present = 1'b1;
      expect_op(0, 1'b1, cyc + 1);
      bus.rst_en_bit = 1'b1;
      bus.wr_en_bit  = 1'b1;
      bus.rd_en_bit  = 1'b1;
      bus.wdata_bit  = 1'b0;
      @(negedge clk);
      bus.rst_en_bit = 1'b0;
      bus.wr_en_bit  = 1'b0;
      bus.rd_en_bit  = 1'b0;
      wait_cycles(500);
      bus.wr_en_bit = 1'b1;
      @(negedge clk);
      bus.wr_en_bit = 1'b0;
      wait_rdy(BUSY_MAX);

      // Abort a write-0 with rst: bus released at once, no strobes.
      bus.wr_en_bit = 1'b1;
      bus.wdata_bit = 1'b0;
      @(negedge clk);
      bus.wr_en_bit = 1'b0;
      wait_cycles(100);
      check("abort_pre_dq_oe", {31'd0, bus.dq_oe}, 1);
      #5 rst = 1'b1;
      #1;
      check("abort_dq_oe", {31'd0, bus.dq_oe}, 0);
      check("abort_rdy", {31'd0, bus.rdy_bit}, 0);
      @(negedge clk);
      check("abort_rdata_vld", {31'd0, bus.rdata_vld_bit}, 0);
      check("abort_pres_vld", {31'd0, bus.pres_vld}, 0);
      @(negedge clk);
      rst = 1'b0;
      ev_q.push_back(mk_ev(EV_RDY, 1'b0, cyc + 1));
      wait_rdy(10);
      issue(1, 1'b0);

      // Randomized operations.
      n_rst = 0;
      for (int i = 0; i < 30; i++) begin
         wait_cycles($urandom_range(0, 20));
         op  = $urandom_range(0, 9);
         val = 1'($urandom_range(0, 1));
         if (op == 0 && n_rst < 3) begin
            n_rst++;
            issue(0, val);
         end else if (op < 5) begin
            issue(1, val);
         end else begin
            issue(2, val);
         end
      end

      // Drain: nothing left pending and no stray activity.
      wait_cycles(300);
      check("drain_events", ev_q.size(), 0);
      check("drain_pulses", pulse_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard bound on total run time.
   initial begin
      #(90000 * 40);
      $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
